// File: rtl/matrix_loader_pkg.sv
// rtl/matrix_loader_pkg.sv - shared types and constants for the matrix stream loader
package matrix_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        STREAM,
        WAIT_DONE
    } loader_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIMS    = 2'd1;
    localparam logic [1:0] ERR_EARLY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int ELEM_CNT_W = 16;

endpackage

// File: rtl/matrix_stream_loader_if.sv
// rtl/matrix_stream_loader_if.sv - host header, element stream and storage write-port bundle
interface matrix_stream_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            matrix_id;
    logic [7:0]            rows;
    logic [7:0]            cols;
    logic [63:0]           matrix_name;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            err_code;
    logic                  write_req;
    logic [2:0]            write_matrix_id;
    logic [7:0]            write_rows;
    logic [7:0]            write_cols;
    logic [63:0]           write_matrix_name;
    logic [DATA_WIDTH-1:0] write_data_in;
    logic                  write_data_valid;
    logic                  write_done;
    logic                  writer_ready;

    modport slave (
        input  start, matrix_id, rows, cols, matrix_name, s_data, s_valid,
        input  write_done, writer_ready,
        output s_ready, busy, done, error, err_code, write_req,
        output write_matrix_id, write_rows, write_cols, write_matrix_name,
        output write_data_in, write_data_valid
    );

    modport master (
        output start, matrix_id, rows, cols, matrix_name, s_data, s_valid,
        output write_done, writer_ready,
        input  s_ready, busy, done, error, err_code, write_req,
        input  write_matrix_id, write_rows, write_cols, write_matrix_name,
        input  write_data_in, write_data_valid
    );

endinterface

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - validates a matrix header and forwards rows*cols elements to storage
module matrix_stream_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_ELEMS      = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_stream_loader_if.slave bus
);

    localparam int                    TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ELEM_CNT_W-1:0] MAX_TOTAL = ELEM_CNT_W'(MAX_ELEMS);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    loader_state_e         state_q, state_d;
    logic [ELEM_CNT_W-1:0] total_q, total_d;
    logic [ELEM_CNT_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [TO_W-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic [2:0]            id_q, id_d;
    logic [7:0]            rows_q, rows_d;
    logic [7:0]            cols_q, cols_d;
    logic [63:0]           name_q, name_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wreq_q, wreq_d;
    logic                  s_ready_q, s_ready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [ELEM_CNT_W-1:0] dims_product;
    logic                  accept;

    assign dims_product = ELEM_CNT_W'(rows_q) * ELEM_CNT_W'(cols_q);
    assign accept       = s_ready_q & bus.s_valid;

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        elem_cnt_d    = elem_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        id_d          = id_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        name_d        = name_q;
        wdata_d       = wdata_q;
        err_code_d    = err_code_q;
        wvalid_d      = 1'b0;
        wreq_d        = 1'b0;
        s_ready_d     = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    id_d          = bus.matrix_id;
                    rows_d        = bus.rows;
                    cols_d        = bus.cols;
                    name_d        = bus.matrix_name;
                    err_code_d    = ERR_NONE;
                    elem_cnt_d    = '0;
                    timeout_cnt_d = '0;
                    state_d       = CHECK;
                end
            end
            CHECK: begin
                total_d = dims_product;
                if (rows_q == 8'd0 || cols_q == 8'd0 || dims_product > MAX_TOTAL) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DIMS;
                    state_d    = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.writer_ready) begin
                    wreq_d    = 1'b1;
                    s_ready_d = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                // Completion before our final beat is on the bus is always premature.
                if (bus.write_done) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_EARLY;
                    state_d    = IDLE;
                end else begin
                    if (accept) begin
                        wdata_d    = bus.s_data;
                        wvalid_d   = 1'b1;
                        elem_cnt_d = elem_cnt_q + ELEM_CNT_W'(1);
                    end
                    if (elem_cnt_d == total_q) begin
                        timeout_cnt_d = '0;
                        state_d       = WAIT_DONE;
                    end else begin
                        s_ready_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.write_done) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timeout_cnt_q == TO_LAST) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            total_q       <= '0;
            elem_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            id_q          <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            name_q        <= '0;
            wdata_q       <= '0;
            wvalid_q      <= 1'b0;
            wreq_q        <= 1'b0;
            s_ready_q     <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            elem_cnt_q    <= elem_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            id_q          <= id_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            name_q        <= name_d;
            wdata_q       <= wdata_d;
            wvalid_q      <= wvalid_d;
            wreq_q        <= wreq_d;
            s_ready_q     <= s_ready_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.s_ready           = s_ready_q;
    assign bus.done              = done_q;
    assign bus.error             = error_q;
    assign bus.err_code          = err_code_q;
    assign bus.write_req         = wreq_q;
    assign bus.write_matrix_id   = id_q;
    assign bus.write_rows        = rows_q;
    assign bus.write_cols        = cols_q;
    assign bus.write_matrix_name = name_q;
    assign bus.write_data_in     = wdata_q;
    assign bus.write_data_valid  = wvalid_q;

endmodule
